// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a prefetch FIFO, req/ack imem port and redirect flush.
// Define FETCH_BYPASS_EN to forward an ack into an empty queue straight to decode in the same cycle.
module fetch_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_ack,
    input  logic [DATA_W-1:0]      imem_rdata,
    output logic                   ins_valid,
    output logic [DATA_W-1:0]      ins_data,
    output logic [ADDR_W-1:0]      ins_pc,
    input  logic                   ins_ready,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, pc_nxt, addr_nxt, target;
    logic              req_nxt, take, push, pop, empty;
    logic [ADDR_W-1:0] pc_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       count;

    assign target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign empty      = (count == '0);
    assign fifo_count = count;
    assign pop        = !empty && ins_ready && !redirect;

    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        req_nxt   = imem_req;
        addr_nxt  = imem_addr;
        take      = 1'b0;
        case (state)
            IDLE: begin
                // a redirect empties the queue, so it can always issue at once
                if (redirect || count != FULL) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = redirect ? target : fetch_pc;
                    pc_nxt    = redirect ? target : fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = imem_ack ? IDLE : DROP;
                    req_nxt   = !imem_ack;
                end else if (imem_ack) begin
                    take      = 1'b1;
                    pc_nxt    = fetch_pc + ADDR_W'(4);
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            DROP: begin
                pc_nxt    = redirect ? target : fetch_pc;
                state_nxt = imem_ack ? IDLE : DROP;
                req_nxt   = !imem_ack;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass    = empty && take;
    assign push      = take && !(bypass && ins_ready);
    assign ins_valid = !empty || bypass;
    assign ins_data  = !empty ? data_mem[rd_ptr] : (bypass ? imem_rdata : '0);
    assign ins_pc    = !empty ? pc_mem[rd_ptr] : (bypass ? imem_addr : '0);
`else
    assign push      = take;
    assign ins_valid = !empty;
    assign ins_data  = !empty ? data_mem[rd_ptr] : '0;
    assign ins_pc    = !empty ? pc_mem[rd_ptr] : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            count  <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= imem_addr;
            data_mem[wr_ptr] <= imem_rdata;
        end
    end

    // issue is gated on a free slot, so this only fires on a broken handshake
    assert property (@(posedge clk) disable iff (!rst_n) !(push && count == FULL))
        else $error("fetch_unit: push into full queue");
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard plus vector-table bench for fetch_unit with a latency-programmable memory.
module tb_fetch_unit;
    localparam int AW = 16;
    localparam int DW = 32;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b1, redirect = 1'b0, ins_ready = 1'b0;
    logic          imem_req, imem_ack, ins_valid;
    logic [AW-1:0] redirect_pc = '0, imem_addr, ins_pc;
    logic [DW-1:0] imem_rdata, ins_data;
    logic [2:0]    fifo_count;
    int            errors = 0, checks = 0;
    int            mem_lat = 0, wait_cnt = 0, pops = 0, base = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
        .fifo_count(fifo_count)
    );

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {16'hBEEF, a};
    endfunction

    // memory acks once the request has waited mem_lat cycles
    assign imem_ack   = rst_n && imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = imem_ack ? word_of(imem_addr) : 32'hDEAD_DEAD;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else        wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {logic [AW-1:0] pc; logic [DW-1:0] data;} ent_t;
    ent_t          sb[$];
    ent_t          e_mon;
    logic [AW-1:0] popped[$];
    logic [AW-1:0] exp_pc = '0, held_addr = '0;
    bit            dropping = 0, pend = 0, byp = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_pc   = '0;
            dropping = 0;
            pend     = 0;
        end else begin
            byp = BYP && sb.size() == 0 && imem_req && imem_ack && !redirect && !dropping;
            chk("fifo_count", fifo_count, sb.size());
            chk("ins_valid", ins_valid, sb.size() != 0 || byp);
            if (sb.size() == 0 && !byp) begin
                chk("empty_pc", ins_pc, 0);
                chk("empty_data", ins_data, 0);
            end
            if (pend) begin
                chk("hold_req", imem_req, 1);
                chk("hold_addr", imem_addr, held_addr);
            end
            pend      = imem_req && !imem_ack;
            held_addr = imem_addr;
            if (redirect) begin
                sb.delete();
                if (imem_req && !imem_ack) dropping = 1;
                else if (imem_ack)         dropping = 0;
                exp_pc = redirect_pc & 16'hFFFC;
            end else begin
                if (imem_ack) begin
                    if (dropping) dropping = 0;
                    else begin
                        chk("req_addr", imem_addr, exp_pc);
                        e_mon.pc   = exp_pc;
                        e_mon.data = word_of(exp_pc);
                        sb.push_back(e_mon);
                        exp_pc += 16'd4;
                    end
                end
                if (ins_valid && ins_ready && sb.size() != 0) begin
                    e_mon = sb.pop_front();
                    chk("pop_pc", ins_pc, e_mon.pc);
                    chk("pop_data", ins_data, e_mon.data);
                    popped.push_back(ins_pc);
                    pops++;
                end
            end
        end
    end

    typedef struct {logic ready; logic req; logic [AW-1:0] addr; logic [2:0] cnt; logic [AW-1:0] pc;} vec_t;
    vec_t          tv[13];
    logic [AW-1:0] wrap_exp[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst_n = 1'b0;
        redirect = 1'b0;
        ins_ready = 1'b0;
        mem_lat = lat;
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", ins_valid, 0);
        chk("rst_data", ins_data, 0);
        chk("rst_pc", ins_pc, 0);
        chk("rst_count", fifo_count, 0);
        popped.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        tv[0]  = '{1'b0, 1'b1, 16'h0000, 3'd0, 16'h0000};
        tv[1]  = '{1'b0, 1'b0, 16'h0000, 3'd1, 16'h0000};
        tv[2]  = '{1'b0, 1'b1, 16'h0004, 3'd1, 16'h0000};
        tv[3]  = '{1'b0, 1'b0, 16'h0004, 3'd2, 16'h0000};
        tv[4]  = '{1'b0, 1'b1, 16'h0008, 3'd2, 16'h0000};
        tv[5]  = '{1'b0, 1'b0, 16'h0008, 3'd3, 16'h0000};
        tv[6]  = '{1'b0, 1'b1, 16'h000C, 3'd3, 16'h0000};
        tv[7]  = '{1'b0, 1'b0, 16'h000C, 3'd4, 16'h0000};
        tv[8]  = '{1'b0, 1'b0, 16'h000C, 3'd4, 16'h0000};
        tv[9]  = '{1'b0, 1'b0, 16'h000C, 3'd4, 16'h0000};
        tv[10] = '{1'b1, 1'b0, 16'h000C, 3'd3, 16'h0004};
        tv[11] = '{1'b0, 1'b1, 16'h0010, 3'd3, 16'h0004};
        tv[12] = '{1'b0, 1'b0, 16'h0010, 3'd4, 16'h0004};
        wrap_exp = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        #2;

        // zero-wait memory, decode always ready
        do_reset(0);
        ins_ready = 1'b1;
        base = pops;
        tick();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        chk("t1_valid_c1", ins_valid, BYP);
        tick();
        chk("t1_valid_c2", ins_valid, !BYP);
        chk("t1_count_c2", fifo_count, BYP ? 0 : 1);
        repeat (10) tick();
        chk("t1_rate", pops - base, BYP ? 6 : 5);
        chk("t1_npop", popped.size() >= 3, 1);
        for (int i = 0; i < 3; i++) chk("t1_seq", popped[i], 4 * i);

        // decode stalled: queue fills, then one pop lets fetch resume
        do_reset(0);
        for (int i = 0; i < 13; i++) begin
            ins_ready = tv[i].ready;
            tick();
            chk("t2_req", imem_req, tv[i].req);
            chk("t2_addr", imem_addr, tv[i].addr);
            chk("t2_count", fifo_count, tv[i].cnt);
            chk("t2_pc", ins_pc, tv[i].pc);
        end

        // slow memory, redirect while the request is outstanding
        do_reset(3);
        ins_ready = 1'b1;
        tick();
        chk("t3_req", imem_req, 1);
        redirect = 1'b1;
        redirect_pc = 16'h0102;
        tick();
        redirect = 1'b0;
        chk("t3_drop_req", imem_req, 1);
        chk("t3_drop_addr", imem_addr, 0);
        tick();
        tick();
        chk("t3_wait_addr", imem_addr, 0);
        tick();
        chk("t3_idle_req", imem_req, 0);
        chk("t3_idle_count", fifo_count, 0);
        chk("t3_idle_valid", ins_valid, 0);
        tick();
        chk("t3_new_req", imem_req, 1);
        chk("t3_new_addr", imem_addr, 16'h0100);
        repeat (12) tick();
        chk("t3_npop", popped.size() >= 1, 1);
        chk("t3_first", popped[0], 16'h0100);

        // redirect coinciding with ack and pop, three entries queued
        do_reset(0);
        repeat (7) tick();
        chk("t4_pre_count", fifo_count, 3);
        chk("t4_pre_req", imem_req, 1);
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        ins_ready = 1'b1;
        tick();
        redirect = 1'b0;
        chk("t4_count", fifo_count, 0);
        chk("t4_valid", ins_valid, 0);
        chk("t4_req", imem_req, 0);
        tick();
        chk("t4_next_req", imem_req, 1);
        chk("t4_next_addr", imem_addr, 16'h0200);
        repeat (4) tick();

        // address wrap at the top of the space
        do_reset(0);
        ins_ready = 1'b1;
        repeat (3) tick();
        redirect = 1'b1;
        redirect_pc = 16'hFFF8;
        popped.delete();
        tick();
        redirect = 1'b0;
        repeat (14) tick();
        chk("t5_npop", popped.size() >= 4, 1);
        for (int i = 0; i < 4; i++) chk("t5_wrap", popped[i], wrap_exp[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
